rca_shared_arbiter: RTL and testbench

Round-robin scheduler that shares a single `ripple_carry_adder_7bit` instance among `NUM_REQ` requesters. Each requester presents two `WIDTH`-bit operands with a valid/ready handshake. The arbiter grants one requester and registers its operands into the adder. It holds them for `SETTLE_CYCLES` clocks so the ripple chain settles, then captures the `WIDTH+1`-bit sum. The sum is returned on a single response channel tagged with the requester ID. The block sits between the operand producers and the combinational adder datapath.

---
 rtl/rca_arb_pkg.sv | 31 +++
 rtl/ripple_carry_adder_7bit.sv | 26 ++
 rtl/rca_shared_arbiter.sv | 124 ++++++++++++
 tb/tb_rca_shared_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rca_arb_pkg.sv
// Shared types and helpers for the round-robin adder arbiter.
// State encoding, ID width sizing and rotating priority pick.
package rca_arb_pkg;

   localparam int MAX_REQ = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   function automatic int id_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // First set bit at or above ptr, wrapping modulo n; -1 when none is set.
   function automatic int rr_pick(
      input logic [MAX_REQ-1:0] vec,
      input int                 n,
      input int                 ptr
   );
      int idx;
      rr_pick = -1;
      for (int k = n - 1; k >= 0; k--) begin
         idx = (ptr + k) % n;
         if (vec[idx[4:0]]) rr_pick = idx;
      end
   endfunction

endpackage

// File: rtl/ripple_carry_adder_7bit.sv
// Combinational ripple-carry adder; result is {carry, sum}.
// Carry propagates bit by bit from the LSB.
module ripple_carry_adder_7bit #(
   parameter int WIDTH = 7
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH:0]   o_sum
);

   logic [WIDTH:0] w_sum;
   logic           w_cy;

   always_comb begin
      w_sum = '0;
      w_cy  = 1'b0;
      for (int k = 0; k < WIDTH; k++) begin
         w_sum[k] = i_a[k] ^ i_b[k] ^ w_cy;
         w_cy     = (i_a[k] & i_b[k]) | (w_cy & (i_a[k] ^ i_b[k]));
      end
      w_sum[WIDTH] = w_cy;
   end

   assign o_sum = w_sum;

endmodule

// File: rtl/rca_shared_arbiter.sv
// Round-robin scheduler sharing one ripple-carry adder among requesters.
// Operands are held for a settle period before the sum is captured.
module rca_shared_arbiter
   import rca_arb_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int WIDTH         = 7,
   parameter int SETTLE_CYCLES = 2,
   parameter int ID_W          = id_width(NUM_REQ)
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [NUM_REQ-1:0]       i_req_valid,
   output logic [NUM_REQ-1:0]       o_req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] i_req_term1,
   input  logic [NUM_REQ*WIDTH-1:0] i_req_term2,
   output logic                     o_rsp_valid,
   input  logic                     i_rsp_ready,
   output logic [WIDTH:0]           o_rsp_result,
   output logic [ID_W-1:0]          o_rsp_id,
   output logic                     o_busy
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_t1;
   logic [WIDTH-1:0] r_t2;
   logic [ID_W-1:0]  r_id;
   logic [ID_W-1:0]  r_rr_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH:0]   r_result;
   logic [ID_W-1:0]  r_rsp_id;
   logic             r_rsp_valid;

   logic [MAX_REQ-1:0] w_valid_ext;
   int                 w_pick;
   logic               w_any;
   logic [ID_W-1:0]    w_winner;
   logic [ID_W-1:0]    w_next_ptr;
   logic [WIDTH-1:0]   w_t1;
   logic [WIDTH-1:0]   w_t2;
   logic [WIDTH:0]     w_sum;

   assign w_valid_ext = MAX_REQ'(i_req_valid);
   assign w_pick      = rr_pick(w_valid_ext, NUM_REQ, int'(r_rr_ptr));
   assign w_any       = (w_pick >= 0);
   assign w_winner    = ID_W'(w_pick);
   assign w_next_ptr  = (w_winner == ID_W'(NUM_REQ - 1)) ?
                        '0 : w_winner + 1'b1;

   // Ready is suppressed during reset even though valid may be high.
   assign o_req_ready = (r_state == ST_IDLE && w_any && !i_rst) ?
                        ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner) : '0;

   always_comb begin
      w_t1 = '0;
      w_t2 = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (w_winner == ID_W'(k)) begin
            w_t1 = i_req_term1[k*WIDTH +: WIDTH];
            w_t2 = i_req_term2[k*WIDTH +: WIDTH];
         end
      end
   end

   // Adder sees only the latched operands, never the live buses.
   ripple_carry_adder_7bit #(
      .WIDTH (WIDTH)
   ) u_adder (
      .i_a   (r_t1),
      .i_b   (r_t2),
      .o_sum (w_sum)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_t1        <= '0;
         r_t2        <= '0;
         r_id        <= '0;
         r_rr_ptr    <= '0;
         r_cnt       <= '0;
         r_result    <= '0;
         r_rsp_id    <= '0;
         r_rsp_valid <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_t1     <= w_t1;
                  r_t2     <= w_t2;
                  r_id     <= w_winner;
                  r_cnt    <= CNT_W'(SETTLE_CYCLES);
                  r_rr_ptr <= w_next_ptr;
                  r_state  <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CNT_W'(1)) begin
                  r_result    <= w_sum;
                  r_rsp_id    <= r_id;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (i_rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_rsp_valid  = r_rsp_valid;
   assign o_rsp_result = r_result;
   assign o_rsp_id     = r_rsp_id;
   assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rca_shared_arbiter.sv
// Directed scoreboard bench for rca_shared_arbiter.
// Expected {id, sum} pushed at grant, popped at response.
module tb_rca_shared_arbiter;

   localparam int N = 4;
   localparam int W = 7;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] term1;
   logic [N*W-1:0] term2;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [W:0]     rsp_result;
   logic [1:0]     rsp_id;
   logic           busy;

   int             errs;
   int             checks;
   int             m_ptr;
   logic [9:0]     sb_q[$];

   rca_shared_arbiter dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_term1  (term1),
      .i_req_term2  (term2),
      .o_rsp_valid  (rsp_valid),
      .i_rsp_ready  (rsp_ready),
      .o_rsp_result (rsp_result),
      .o_rsp_id     (rsp_id),
      .o_busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int m_pick(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++)
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   task automatic set_ops(input int k, input logic [W-1:0] a,
                          input logic [W-1:0] b);
      term1[k*W +: W] = a;
      term2[k*W +: W] = b;
   endtask

   // Entered just after a rising edge with the DUT idle.
   task automatic do_txn(input logic [N-1:0] vld, input int hold,
                         input bit poke0, input bit corrupt);
      int         w;
      int         n;
      logic [9:0] e;
      logic [W-1:0] a;
      logic [W-1:0] b;
      req_valid = vld;
      rsp_ready = (hold == 0);
      @(negedge clk);
      w = m_pick(vld, m_ptr);
      chk("idle_busy", busy, 0);
      chk("grant", req_ready, 32'(1) << w);
      a = term1[w*W +: W];
      b = term2[w*W +: W];
      sb_q.push_back({2'(w), {1'b0, a} + {1'b0, b}});
      m_ptr = (w + 1) % N;
      @(posedge clk);
      #1;
      if (poke0) req_valid[0] = 1'b1;
      if (corrupt) term1[w*W +: W] = ~a;
      n = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         chk("busy_ready", req_ready, 0);
         if (rsp_valid) begin
            n = c;
            break;
         end
         @(posedge clk);
         #1;
         if (poke0 && c == 1) req_valid[0] = 1'b0;
      end
      if (n == 0) begin
         chk("rsp_timeout", 0, 1);
         void'(sb_q.pop_front());
         return;
      end
      chk("latency", n, 3);
      e = sb_q[0];
      for (int h = 0; h < hold; h++) begin
         chk("hold_valid", rsp_valid, 1);
         chk("hold_result", rsp_result, e[7:0]);
         chk("hold_id", rsp_id, e[9:8]);
         chk("hold_noready", req_ready, 0);
         @(posedge clk);
         #1;
         if (h == hold - 1) rsp_ready = 1'b1;
         @(negedge clk);
      end
      e = sb_q.pop_front();
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_result", rsp_result, e[7:0]);
      chk("rsp_id", rsp_id, e[9:8]);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_valid = '0;
      rsp_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_result", rsp_result, 0);
      chk("rst_id", rsp_id, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_ptr = 0;
      sb_q.delete();
      @(posedge clk);
      #1;
   endtask

   initial begin
      errs = 0;
      checks = 0;
      m_ptr = 0;
      rst = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      term1 = '0;
      term2 = '0;
      #2;
      do_reset();

      set_ops(2, 7'h05, 7'h03);
      do_txn(4'b0100, 0, 1'b0, 1'b0);

      set_ops(1, 7'h7F, 7'h7F);
      do_txn(4'b0010, 5, 1'b0, 1'b0);

      set_ops(3, 7'h21, 7'h40);
      do_txn(4'b1000, 0, 1'b1, 1'b0);
      set_ops(0, 7'h11, 7'h22);
      set_ops(3, 7'h33, 7'h0C);
      do_txn(4'b1000, 1, 1'b0, 1'b0);

      set_ops(0, 7'h2A, 7'h15);
      do_txn(4'b0001, 0, 1'b0, 1'b1);
      set_ops(0, 7'h11, 7'h22);

      // Reset while an operation is settling.
      req_valid = 4'b1111;
      @(negedge clk);
      chk("pre_rst_grant", req_ready, 32'(1) << m_pick(4'b1111, m_ptr));
      @(posedge clk);
      #1;
      chk("settle_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("mid_ready", req_ready, 0);
      chk("mid_valid", rsp_valid, 0);
      chk("mid_result", rsp_result, 0);
      chk("mid_id", rsp_id, 0);
      chk("mid_busy", busy, 0);
      req_valid = '0;
      @(negedge clk);
      rst = 1'b0;
      m_ptr = 0;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("no_stale", rsp_valid, 0);
      @(posedge clk);
      #1;
      set_ops(1, 7'h0F, 7'h01);
      set_ops(2, 7'h50, 7'h2F);
      do_txn(4'b0110, 0, 1'b0, 1'b0);

      do_reset();
      for (int k = 0; k < N; k++)
         set_ops(k, 7'(8 * k + 3), 7'(7'h7F - 5 * k));
      for (int r = 0; r < 5; r++)
         do_txn(4'b1111, 0, 1'b0, 1'b0);

      chk("sb_empty", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "watchdog");
   end

endmodule
